// File: rtl/peripheral_arbiter_wb.sv
// peripheral_arbiter_wb
//   Round-robin Wishbone arbiter sharing one slave port between MASTERS masters.
//   The grant is held for the owner's whole cycle (cyc high), so bursts are never split.
//   A response watchdog ends accesses the slave never answers with an error to the owner.
//
// Ports
//   wb_clk, wb_rst          clock, asynchronous active-high reset
//   wbm_*_i                 packed master request vectors, master i at slice [i*W +: W]
//   wbm_dat/ack/err/rty_o   per-master responses, only the owner sees non-zero values
//   wbs_*_o                 request of the current owner, all zero while idle
//   wbs_dat/ack/err/rty_i   slave responses
//   grant_o                 registered one-hot grant, zero while idle
module peripheral_arbiter_wb #(
   parameter int unsigned MASTERS = 2,
   parameter int unsigned DW      = 32,
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TW      = 8
) (
   input  logic                    wb_clk,
   input  logic                    wb_rst,
   input  logic [MASTERS*AW-1:0]   wbm_adr_i,
   input  logic [MASTERS*DW-1:0]   wbm_dat_i,
   input  logic [MASTERS*DW/8-1:0] wbm_sel_i,
   input  logic [MASTERS-1:0]      wbm_we_i,
   input  logic [MASTERS-1:0]      wbm_cyc_i,
   input  logic [MASTERS-1:0]      wbm_stb_i,
   input  logic [MASTERS*3-1:0]    wbm_cti_i,
   input  logic [MASTERS*2-1:0]    wbm_bte_i,
   output logic [MASTERS*DW-1:0]   wbm_dat_o,
   output logic [MASTERS-1:0]      wbm_ack_o,
   output logic [MASTERS-1:0]      wbm_err_o,
   output logic [MASTERS-1:0]      wbm_rty_o,
   output logic [AW-1:0]           wbs_adr_o,
   output logic [DW-1:0]           wbs_dat_o,
   output logic [DW/8-1:0]         wbs_sel_o,
   output logic                    wbs_we_o,
   output logic                    wbs_cyc_o,
   output logic                    wbs_stb_o,
   output logic [2:0]              wbs_cti_o,
   output logic [1:0]              wbs_bte_o,
   input  logic [DW-1:0]           wbs_dat_i,
   input  logic                    wbs_ack_i,
   input  logic                    wbs_err_i,
   input  logic                    wbs_rty_i,
   output logic [MASTERS-1:0]      grant_o
);

   localparam int unsigned IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int unsigned SW = DW / 8;
   localparam bit WD_EN = (TIMEOUT > 0);
   // The timeout fires in the cycle whose stall would make the count reach TIMEOUT.
   localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [0:0] {StIdle, StOwned} state_e;

   state_e              state_q;
   logic [IW-1:0]       owner_q;
   logic [IW-1:0]       last_q;
   logic [MASTERS-1:0]  grant_q;
   logic [TW-1:0]       wd_cnt_q;

   logic                owned;
   logic                resp;
   logic                stall;
   logic                timeout;
   logic [IW-1:0]       scan_base;
   logic [IW-1:0]       cand;
   logic                pick_valid;
   logic [IW-1:0]       pick_idx;
   logic [MASTERS-1:0]  pick_oh;

   assign owned   = (state_q == StOwned);
   assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
   // Stall is judged on the owner's own request so the forced-low slave strobe cannot feed back.
   assign stall   = owned & wbm_cyc_i[owner_q] & wbm_stb_i[owner_q] & ~resp;
   assign timeout = WD_EN & stall & (wd_cnt_q == WD_LAST);
   assign grant_o = grant_q;

   // Round-robin scan starting after the base; descending offsets let the nearest requester win.
   // On release the base is the outgoing owner, which therefore comes last in the scan.
   always_comb begin
      scan_base  = owned ? owner_q : last_q;
      cand       = '0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      pick_oh    = '0;
      for (int off = MASTERS; off >= 1; off--) begin
         cand = IW'((int'(scan_base) + off) % MASTERS);
         if (wbm_cyc_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
      if (pick_valid) pick_oh[pick_idx] = 1'b1;
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q  <= StIdle;
         owner_q  <= '0;
         last_q   <= IW'(MASTERS - 1);
         grant_q  <= '0;
         wd_cnt_q <= '0;
      end else begin
         if (WD_EN && stall && !timeout) wd_cnt_q <= wd_cnt_q + 1'b1;
         else                            wd_cnt_q <= '0;

         case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  state_q <= StOwned;
                  owner_q <= pick_idx;
                  grant_q <= pick_oh;
               end
            end
            StOwned: begin
               if (!wbm_cyc_i[owner_q]) begin
                  last_q <= owner_q;
                  if (pick_valid) begin
                     owner_q <= pick_idx;
                     grant_q <= pick_oh;
                  end else begin
                     state_q <= StIdle;
                     grant_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= '0;
            end
         endcase
      end
   end

   // Request mux towards the slave and response demux back to the owner.
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      if (owned) begin
         wbs_adr_o = wbm_adr_i[int'(owner_q)*AW +: AW];
         wbs_dat_o = wbm_dat_i[int'(owner_q)*DW +: DW];
         wbs_sel_o = wbm_sel_i[int'(owner_q)*SW +: SW];
         wbs_we_o  = wbm_we_i[owner_q];
         wbs_cyc_o = wbm_cyc_i[owner_q] & ~timeout;
         wbs_stb_o = wbm_stb_i[owner_q] & ~timeout;
         wbs_cti_o = wbm_cti_i[int'(owner_q)*3 +: 3];
         wbs_bte_o = wbm_bte_i[int'(owner_q)*2 +: 2];
      end
      wbm_dat_o = '0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      for (int m = 0; m < MASTERS; m++) begin
         wbm_ack_o[m] = grant_q[m] & wbs_ack_i;
         wbm_err_o[m] = grant_q[m] & (wbs_err_i | timeout);
         wbm_rty_o[m] = grant_q[m] & wbs_rty_i;
         if (grant_q[m]) wbm_dat_o[m*DW +: DW] = wbs_dat_i;
      end
   end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
module tb_peripheral_arbiter_wb;

   localparam int M  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic wb_clk = 1'b0;
   logic wb_rst = 1'b1;
   always #5 wb_clk = ~wb_clk;

   logic [M*AW-1:0]   m_adr;
   logic [M*DW-1:0]   m_dat;
   logic [M*DW/8-1:0] m_sel;
   logic [M-1:0]      m_we, m_cyc, m_stb;
   logic [M*3-1:0]    m_cti;
   logic [M*2-1:0]    m_bte;
   logic [M*DW-1:0]   wbm_dat_o;
   logic [M-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
   logic [AW-1:0]     wbs_adr_o;
   logic [DW-1:0]     wbs_dat_o;
   logic [DW/8-1:0]   wbs_sel_o;
   logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
   logic [2:0]        wbs_cti_o;
   logic [1:0]        wbs_bte_o;
   logic [DW-1:0]     s_dat;
   logic              s_ack, s_err, s_rty;

   peripheral_arbiter_wb #(
      .MASTERS(M), .DW(DW), .AW(AW), .TIMEOUT(TO), .TW(8)
   ) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
      .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
      .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
      .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .grant_o(grant_o)
   );

   int total = 0;
   int bad   = 0;
   // Reference model: current owner (-1 = nobody), last owner, consecutive stalled cycles.
   int mo, mlast, mstall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_timeout();
      if (mo < 0) return 1'b0;
      return m_cyc[mo] && m_stb[mo] && !(s_ack || s_err || s_rty) && (mstall == TO - 1);
   endfunction

   task automatic check_all();
      bit          to;
      logic [63:0] e;
      to = model_timeout();
      if (mo < 0) begin
         chk("grant", grant_o, 0);
         chk("s_cyc", wbs_cyc_o, 0);
         chk("s_stb", wbs_stb_o, 0);
         chk("s_adr", wbs_adr_o, 0);
         chk("m_ack", wbm_ack_o, 0);
         chk("m_err", wbm_err_o, 0);
         chk("m_rty", wbm_rty_o, 0);
         chk("m_dat", wbm_dat_o, 0);
      end else begin
         chk("grant", grant_o, 64'(1) << mo);
         chk("s_cyc", wbs_cyc_o, m_cyc[mo] & !to);
         chk("s_stb", wbs_stb_o, m_stb[mo] & !to);
         chk("s_adr", wbs_adr_o, m_adr[mo*AW +: AW]);
         chk("s_dat", wbs_dat_o, m_dat[mo*DW +: DW]);
         chk("s_sel", wbs_sel_o, m_sel[mo*4 +: 4]);
         chk("s_we", wbs_we_o, m_we[mo]);
         chk("s_cti", wbs_cti_o, m_cti[mo*3 +: 3]);
         chk("s_bte", wbs_bte_o, m_bte[mo*2 +: 2]);
         chk("m_ack", wbm_ack_o, 64'(s_ack) << mo);
         chk("m_err", wbm_err_o, 64'(s_err | to) << mo);
         chk("m_rty", wbm_rty_o, 64'(s_rty) << mo);
         e = '0;
         e[mo*DW +: DW] = s_dat;
         chk("m_dat", wbm_dat_o, e);
      end
   endtask

   task automatic model_edge();
      bit to;
      to = model_timeout();
      if (mo >= 0 && m_cyc[mo] && m_stb[mo] && !(s_ack || s_err || s_rty) && !to) mstall++;
      else mstall = 0;
      if (mo < 0 || !m_cyc[mo]) begin
         if (mo >= 0) mlast = mo;
         mo = -1;
         for (int k = 1; k <= M; k++)
            if (mo < 0 && m_cyc[(mlast + k) % M]) mo = (mlast + k) % M;
      end
   endtask

   // Inputs are driven at posedge+1; outputs checked at +2, model advanced, then next edge.
   task automatic tick();
      #1;
      check_all();
      model_edge();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
      m_cyc[i] = cyc;
      m_stb[i] = stb;
      m_we[i]  = we;
      m_adr[i*AW +: AW] = adr;
      m_dat[i*DW +: DW] = dat;
      m_sel[i*4 +: 4]   = 4'hF;
      m_cti[i*3 +: 3]   = cti;
      m_bte[i*2 +: 2]   = 2'b00;
   endtask

   task automatic do_reset();
      wb_rst = 1'b1;
      m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
      m_cti = '0; m_bte = '0;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      mo = -1; mlast = M - 1; mstall = 0;
      repeat (2) @(posedge wb_clk);
      #1;
      wb_rst = 1'b0;
   endtask

   initial begin
      // Reset values
      do_reset();
      wb_rst = 1'b1;
      #1;
      chk("rst_grant", grant_o, 0);
      chk("rst_scyc", wbs_cyc_o, 0);
      chk("rst_sadr", wbs_adr_o, 0);
      chk("rst_ack", wbm_ack_o, 0);
      chk("rst_dat", wbm_dat_o, 0);
      wb_rst = 1'b0;
      @(posedge wb_clk);
      #1;

      // Single write from master 0
      set_m(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 3'b000);
      #1;
      chk("t1_idle_scyc", wbs_cyc_o, 0);
      tick();
      s_ack = 1'b1;
      #1;
      chk("t1_grant", grant_o, 2'b01);
      chk("t1_adr", wbs_adr_o, 32'h100);
      chk("t1_dat", wbs_dat_o, 32'hDEADBEEF);
      chk("t1_sel", wbs_sel_o, 4'hF);
      chk("t1_ack", wbm_ack_o, 2'b01);
      tick();
      s_ack = 1'b0;
      set_m(0, 0, 0, 0, 0, 0, 0);
      tick();
      #1;
      chk("t1_release", grant_o, 2'b00);
      tick();

      // Simultaneous requests: master 0 first, then master 1 with no idle cycle
      do_reset();
      set_m(0, 1, 1, 1, 32'h10, 32'h1, 3'b000);
      set_m(1, 1, 1, 0, 32'h40, 32'h0, 3'b000);
      tick();
      #1;
      chk("t2_first", grant_o, 2'b01);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      set_m(0, 0, 0, 0, 0, 0, 0);
      tick();
      #1;
      chk("t2_handover", grant_o, 2'b10);
      chk("t2_noidle", wbs_cyc_o, 1);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      set_m(1, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Master 1 burst is not split by master 0
      do_reset();
      set_m(1, 1, 1, 1, 32'h200, 32'h0, 3'b010);
      tick();
      set_m(0, 1, 1, 1, 32'h300, 32'h5, 3'b000);
      s_ack = 1'b1;
      for (int b = 0; b < 4; b++) begin
         set_m(1, 1, 1, 1, 32'h200 + 32'(4 * b), 32'(b), (b == 3) ? 3'b111 : 3'b010);
         #1;
         chk("t3_grant", grant_o, 2'b10);
         chk("t3_adr", wbs_adr_o, 32'h200 + 32'(4 * b));
         chk("t3_ack", wbm_ack_o, 2'b10);
         tick();
      end
      s_ack = 1'b0;
      set_m(1, 0, 0, 0, 0, 0, 0);
      tick();
      #1;
      chk("t3_next", grant_o, 2'b01);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      set_m(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Watchdog: slave never answers
      do_reset();
      set_m(0, 1, 1, 0, 32'h400, 32'h0, 3'b000);
      tick();
      for (int s = 1; s <= 4; s++) begin
         #1;
         chk("t4_err", wbm_err_o, (s == 4) ? 2'b01 : 2'b00);
         chk("t4_scyc", wbs_cyc_o, (s == 4) ? 1'b0 : 1'b1);
         chk("t4_ack", wbm_ack_o, 2'b00);
         tick();
      end
      #1;
      chk("t4_held", grant_o, 2'b01);
      set_m(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Reset during beat 2 of a burst
      do_reset();
      set_m(0, 1, 1, 1, 32'h500, 32'h1, 3'b010);
      tick();
      s_ack = 1'b1;
      tick();
      set_m(0, 1, 1, 1, 32'h504, 32'h2, 3'b010);
      set_m(1, 1, 1, 1, 32'h700, 32'h3, 3'b000);
      #1;
      wb_rst = 1'b1;
      #1;
      chk("t5_grant", grant_o, 2'b00);
      chk("t5_scyc", wbs_cyc_o, 0);
      chk("t5_ack", wbm_ack_o, 2'b00);
      do_reset();
      set_m(0, 1, 1, 1, 32'h500, 32'h1, 3'b000);
      set_m(1, 1, 1, 1, 32'h700, 32'h3, 3'b000);
      tick();
      #1;
      chk("t5_prio", grant_o, 2'b01);
      set_m(0, 0, 0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Read returning data to master 1 only
      do_reset();
      set_m(1, 1, 1, 0, 32'h600, 32'h0, 3'b000);
      tick();
      s_dat = 32'h12345678;
      s_ack = 1'b1;
      #1;
      chk("t6_dat1", wbm_dat_o[63:32], 32'h12345678);
      chk("t6_dat0", wbm_dat_o[31:0], 32'h0);
      tick();
      s_ack = 1'b0;
      set_m(1, 0, 0, 0, 0, 0, 0);
      tick();

      // Randomised traffic against the model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < M; i++) begin
            bit cyc;
            cyc = m_cyc[i] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
            set_m(i, cyc, cyc && ($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom, $urandom, 3'($urandom));
            m_sel[i*4 +: 4] = 4'($urandom);
            m_bte[i*2 +: 2] = 2'($urandom);
         end
         s_dat = $urandom;
         s_ack = ($urandom_range(0, 9) < 4);
         s_err = ($urandom_range(0, 19) == 0);
         s_rty = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
